// File: rtl/ahb_master_req_ctrl.sv
// AHB burst master request controller: raises hreq, waits for grant, issues NONSEQ/SEQ beats.
// Optional feature macro: AHB_MASTER_BUSY_EN (adds beat_stall input and BUSY transfers).
package AHB_package;
  typedef enum logic [2:0] {
    SINGLE = 3'b000,
    INCR   = 3'b001,
    WRAP4  = 3'b010,
    INCR4  = 3'b011,
    WRAP8  = 3'b100,
    INCR8  = 3'b101,
    WRAP16 = 3'b110,
    INCR16 = 3'b111
  } hburst_type;
endpackage

module ahb_master_req_ctrl
  import AHB_package::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  hclk,
  input  logic                  hreset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  hburst_type            cmd_burst,
  input  logic                  cmd_write,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  hreq,
  input  logic                  hgrant,
  input  logic                  hwait,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic [1:0]            htrans,
  output hburst_type            hburst,
  output logic                  hwrite,
  output logic [DATA_WIDTH-1:0] hwdata,
  input  logic [DATA_WIDTH-1:0] hrdata
`ifdef AHB_MASTER_BUSY_EN
  ,
  input  logic                  beat_stall
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_XFER
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  hburst_type            r_burst;
  logic                  r_write;
  logic [3:0]            r_last;
  logic [3:0]            r_count;
  logic                  r_dphase;
  logic                  r_dwrite;
  logic [DATA_WIDTH-1:0] r_hwdata;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;

  logic                  w_stall;
  logic                  w_accept;
  logic                  w_last_beat;
  logic [ADDR_WIDTH-1:0] w_mask;
  logic [ADDR_WIDTH-1:0] w_addr_inc;
  logic [ADDR_WIDTH-1:0] w_addr_next;

  function automatic logic [3:0] last_idx(input hburst_type b);
    case (b)
      WRAP4, INCR4:   return 4'd3;
      WRAP8, INCR8:   return 4'd7;
      WRAP16, INCR16: return 4'd15;
      default:        return 4'd0;
    endcase
  endfunction

`ifdef AHB_MASTER_BUSY_EN
  assign w_stall = (r_state == S_XFER) && (r_count != '0) && beat_stall;
`else
  assign w_stall = 1'b0;
`endif

  assign w_accept    = (r_state == S_XFER) && hgrant && !w_stall;
  assign w_last_beat = (r_count == r_last);
  assign wr_ready    = w_accept;

  // Wrapping bursts keep the bits above the wrap boundary; INCR uses an all-ones mask.
  always_comb begin
    w_mask = '1;
    case (r_burst)
      WRAP4:   w_mask = {{(ADDR_WIDTH-6){1'b0}}, 6'h0F};
      WRAP8:   w_mask = {{(ADDR_WIDTH-6){1'b0}}, 6'h1F};
      WRAP16:  w_mask = {{(ADDR_WIDTH-6){1'b0}}, 6'h3F};
      default: w_mask = '1;
    endcase
  end

  assign w_addr_inc  = r_addr + ADDR_WIDTH'(4);
  assign w_addr_next = (r_addr & ~w_mask) | (w_addr_inc & w_mask);

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    hreq      = 1'b0;
    htrans    = 2'b00;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_next = S_REQ;
      end
      S_REQ: begin
        hreq = 1'b1;
        if (hgrant) w_next = S_XFER;
      end
      S_XFER: begin
        hreq = 1'b1;
        if (w_stall)             htrans = 2'b01;
        else if (r_count == '0)  htrans = 2'b10;
        else                     htrans = 2'b11;
        if (w_accept && w_last_beat) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      r_addr  <= '0;
      r_burst <= SINGLE;
      r_write <= 1'b0;
      r_last  <= '0;
      r_count <= '0;
    end else if (r_state == S_IDLE && cmd_valid) begin
      r_addr  <= cmd_addr & ~ADDR_WIDTH'(3);
      r_burst <= cmd_burst;
      r_write <= cmd_write;
      r_last  <= last_idx(cmd_burst);
      r_count <= '0;
    end else if (w_accept) begin
      r_addr  <= w_addr_next;
      r_count <= r_count + 4'd1;
    end
  end

  // Data phase tracks its own beat so the final one can finish after the FSM has moved on.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      r_dphase   <= 1'b0;
      r_dwrite   <= 1'b0;
      r_hwdata   <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      if (r_dphase && !hwait && !r_dwrite) begin
        r_rd_valid <= 1'b1;
        r_rd_data  <= hrdata;
      end
      if (w_accept) begin
        r_dphase <= 1'b1;
        r_dwrite <= r_write;
        r_hwdata <= wr_data;
      end else if (!hwait) begin
        r_dphase <= 1'b0;
      end
    end
  end

  assign haddr    = r_addr;
  assign hburst   = r_burst;
  assign hwrite   = r_write;
  assign hwdata   = r_hwdata;
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_ahb_master_req_ctrl.sv
// Randomized bench for ahb_master_req_ctrl against a transaction-level address/data model.
module tb_ahb_master_req_ctrl;
  import AHB_package::*;

  localparam int AW = 32;
  localparam int DW = 32;
`ifdef AHB_MASTER_BUSY_EN
  localparam bit BUSY_EN = 1'b1;
`else
  localparam bit BUSY_EN = 1'b0;
`endif

  logic          hclk = 1'b0;
  logic          hreset_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0, haddr;
  hburst_type    cmd_burst = SINGLE, hburst;
  logic [DW-1:0] wr_data = '0, rd_data, hwdata, hrdata = '0;
  logic          wr_ready, rd_valid, hreq, hwrite;
  logic          hgrant = 1'b0, hwait = 1'b0, beat_stall = 1'b0;
  logic [1:0]    htrans;

  always #5 hclk = ~hclk;

  ahb_master_req_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut (
    .hclk(hclk), .hreset_n(hreset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_burst(cmd_burst), .cmd_write(cmd_write),
    .wr_data(wr_data), .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid),
    .hreq(hreq), .hgrant(hgrant), .hwait(hwait), .haddr(haddr), .htrans(htrans),
    .hburst(hburst), .hwrite(hwrite), .hwdata(hwdata), .hrdata(hrdata)
`ifdef AHB_MASTER_BUSY_EN
    , .beat_stall(beat_stall)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model state
  bit            m_busy = 0, m_granted = 0, m_write = 0;
  hburst_type    m_burst = SINGLE;
  logic [AW-1:0] m_addrs[$];
  int            m_idx = 0, m_beats = 0;
  bit            dp_open = 0, dp_write = 0, rdv_exp = 0;
  logic [DW-1:0] dp_wdata = '0, rdv_data = '0;
  int            n_wrr = 0;

  // stimulus knobs
  bit            c_pending = 0, c_write = 0;
  logic [AW-1:0] c_addr = '0;
  hburst_type    c_burst = SINGLE;
  int p_grant = 100, p_wait = 0, p_stall = 0;
  int wait_beat = -1, wait_len = 0, wait_left = 0;
  int stall_beat = -1, stall_left = 0;
  bit prev_hreq = 0;

  function automatic int beats_of(input hburst_type b);
    case (b)
      WRAP4, INCR4:   return 4;
      WRAP8, INCR8:   return 8;
      WRAP16, INCR16: return 16;
      default:        return 1;
    endcase
  endfunction

  function automatic bit is_wrap(input hburst_type b);
    return (b == WRAP4) || (b == WRAP8) || (b == WRAP16);
  endfunction

  task automatic load_cmd(input logic [AW-1:0] a, input hburst_type b, input bit w);
    logic [AW-1:0] x;
    logic [AW-1:0] span;
    x = a & ~32'h3;
    m_addrs.delete();
    m_beats = beats_of(b);
    span = AW'(m_beats * 4);
    for (int i = 0; i < m_beats; i++) begin
      m_addrs.push_back(x);
      if (is_wrap(b)) x = x - (x % span) + (((x % span) + 4) % span);
      else            x = x + 4;
    end
    m_burst = b; m_write = w; m_idx = 0;
    m_busy = 1; m_granted = 0;
  endtask

  task automatic step();
    logic [1:0] exp_trans;
    bit acc, was_busy;
    @(negedge hclk);
    hwait = 1'b0;
    if (dp_open) begin
      if (wait_left > 0) begin hwait = 1'b1; wait_left--; end
      else hwait = ($urandom_range(99) < p_wait);
    end
    hgrant = prev_hreq && ($urandom_range(99) < p_grant) && !hwait;
    hrdata = $urandom;
    wr_data = $urandom;
    if (stall_left > 0 && m_busy && m_granted && m_idx == stall_beat) begin
      beat_stall = 1'b1; stall_left--;
    end else beat_stall = ($urandom_range(99) < p_stall);
    if (m_busy) begin
      cmd_valid = $urandom_range(1);
      cmd_addr  = $urandom;
      cmd_burst = hburst_type'($urandom_range(7));
      cmd_write = $urandom_range(1);
    end else begin
      cmd_valid = c_pending; cmd_addr = c_addr; cmd_burst = c_burst; cmd_write = c_write;
    end
    #1;
    check("cmd_ready", cmd_ready, !m_busy);
    check("hreq", hreq, m_busy);
    check("rd_valid", rd_valid, rdv_exp);
    if (rdv_exp) check("rd_data", rd_data, rdv_data);
    if (dp_open && dp_write) check("hwdata", hwdata, dp_wdata);
    exp_trans = 2'b00;
    acc = 0;
    if (m_busy && m_granted) begin
      if (m_idx == 0)                  exp_trans = 2'b10;
      else if (BUSY_EN && beat_stall)  exp_trans = 2'b01;
      else                             exp_trans = 2'b11;
      check("haddr", haddr, m_addrs[m_idx]);
      check("hburst", hburst, m_burst);
      check("hwrite", hwrite, m_write);
      acc = hgrant && (exp_trans != 2'b01);
    end
    check("htrans", htrans, exp_trans);
    check("wr_ready", wr_ready, acc);
    if (wr_ready) n_wrr++;
    was_busy = m_busy;
    rdv_exp  = dp_open && !dp_write && !hwait;
    rdv_data = hrdata;
    if (acc) begin
      dp_open = 1; dp_write = m_write; dp_wdata = wr_data;
      if (m_idx == wait_beat) wait_left = wait_len;
      m_idx++;
      if (m_idx == m_beats) m_busy = 0;
    end else if (!hwait) dp_open = 0;
    if (was_busy && !m_granted && hgrant) m_granted = 1;
    if (!was_busy && cmd_valid) begin
      load_cmd(cmd_addr, cmd_burst, cmd_write);
      c_pending = 0;
    end
    prev_hreq = hreq;
  endtask

  task automatic run_cmd(input logic [AW-1:0] a, input hburst_type b, input bit w);
    int guard;
    guard = 0;
    c_addr = a; c_burst = b; c_write = w; c_pending = 1;
    n_wrr = 0;
    do begin step(); guard++; end while ((c_pending || m_busy) && guard < 2000);
    if (guard >= 2000) check("timeout", 1'b1, 1'b0);
    check("wr_ready_count", n_wrr, beats_of(b));
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) step();
  endtask

  initial begin
    repeat (2) @(negedge hclk);
    #1;
    check("rst_hreq", hreq, 1'b0);
    check("rst_htrans", htrans, 2'b00);
    check("rst_hburst", hburst, SINGLE);
    check("rst_haddr", haddr, '0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_rd_valid", rd_valid, 1'b0);
    @(negedge hclk);
    hreset_n = 1'b1;

    p_grant = 100; p_wait = 0; p_stall = 0;
    run_cmd(32'h100, SINGLE, 1'b1);
    drain();
    run_cmd(32'h200, INCR4, 1'b0);
    drain();
    run_cmd(32'h3C, WRAP8, 1'b1);
    run_cmd(32'h38, WRAP4, 1'b0);
    run_cmd(32'hFFFF_FFF8, INCR4, 1'b1);
    drain();
    wait_beat = 2; wait_len = 3;
    run_cmd(32'h400, INCR4, 1'b1);
    drain();
    run_cmd(32'h480, INCR4, 1'b0);
    drain();
    wait_beat = -1;

    // reset while beat 2 of an INCR8 is on the bus
    c_addr = 32'h800; c_burst = INCR8; c_write = 1'b1; c_pending = 1;
    for (int i = 0; i < 50 && !(m_busy && m_granted && m_idx == 2); i++) step();
    check("reach_beat2", m_idx, 2);
    @(negedge hclk);
    cmd_valid = 1'b0; hgrant = 1'b0; hwait = 1'b0;
    hreset_n = 1'b0;
    #1;
    check("midrst_hreq", hreq, 1'b0);
    check("midrst_htrans", htrans, 2'b00);
    check("midrst_cmd_ready", cmd_ready, 1'b1);
    check("midrst_wr_ready", wr_ready, 1'b0);
    m_busy = 0; m_granted = 0; dp_open = 0; rdv_exp = 0; wait_left = 0; prev_hreq = 0;
    @(negedge hclk);
    hreset_n = 1'b1;
    run_cmd(32'h900, SINGLE, 1'b1);
    drain();

    if (BUSY_EN) begin
      stall_beat = 2; stall_left = 3;
      run_cmd(32'hA00, INCR4, 1'b1);
      stall_beat = -1;
      drain();
    end

    p_grant = 70; p_wait = 30; p_stall = 30;
    for (int n = 0; n < 60; n++)
      run_cmd(AW'($urandom), hburst_type'($urandom_range(7)), 1'($urandom_range(1)));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
